// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB definitions used by the decoder/controller slice:
//   htrans_t    - transfer type encodings (IDLE, BUSY, NONSEQ, SEQ)
//   HRESP_*     - response encodings (OKAY / ERROR)
//   ds_state_t  - default-slave FSM states (IDLE, ERR1, ERR2)
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_decoder_ctrl_if.sv
// ahb_decoder_ctrl_if
// Bus-side signals of the address decoder / data-phase select controller.
//   haddr, htrans, hready    : address phase and combined ready (from master side)
//   hsel_1..hsel_4           : combinational one-hot address-phase selects
//   sel                      : registered data-phase slave index for the response mux
//   dflt_active              : data phase belongs to the built-in default slave
//   hreadyout_dflt, hresp_dflt : default-slave response
// Modports: master (drives address phase, observes decode), slave (the decoder).
interface ahb_decoder_ctrl_if;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel_1;
    logic        hsel_2;
    logic        hsel_3;
    logic        hsel_4;
    logic [1:0]  sel;
    logic        dflt_active;
    logic        hreadyout_dflt;
    logic        hresp_dflt;

    modport master (
        output haddr, htrans, hready,
        input  hsel_1, hsel_2, hsel_3, hsel_4, sel, dflt_active,
               hreadyout_dflt, hresp_dflt
    );

    modport slave (
        input  haddr, htrans, hready,
        output hsel_1, hsel_2, hsel_3, hsel_4, sel, dflt_active,
               hreadyout_dflt, hresp_dflt
    );

endinterface

// File: rtl/ahb_default_slave.sv
// ahb_default_slave
// Built-in default slave: answers active transfers to unmapped addresses with
// a two-cycle ERROR response and keeps error status.
// Ports:
//   hclk, hresetn        : clock, async active-low reset
//   haddr, htrans        : address phase of the current transfer
//   hready               : combined bus ready (accept edge when high)
//   unmapped             : address phase decodes to no slave
//   hreadyout_dflt       : registered default-slave ready
//   hresp_dflt           : registered default-slave response (0 OKAY, 1 ERROR)
//   err_cnt              : saturating count of ERROR transfers
//   last_err_addr        : address of the most recent ERROR transfer
//
// state    | meaning
// DS_IDLE  | no error pending; OKAY, zero wait
// DS_ERR1  | first ERROR cycle, hreadyout low
// DS_ERR2  | second ERROR cycle, hreadyout high; may chain straight into ERR1
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic        unmapped,
    output logic        hreadyout_dflt,
    output logic        hresp_dflt,
    output logic [7:0]  err_cnt,
    output logic [31:0] last_err_addr
);

    ds_state_t state;
    logic      err_start;

    // IDLE and BUSY to an unmapped address get an OKAY, only real transfers error
    assign err_start = hready && unmapped &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state          <= DS_IDLE;
            hreadyout_dflt <= 1'b1;
            hresp_dflt     <= HRESP_OKAY;
            err_cnt        <= 8'd0;
            last_err_addr  <= 32'd0;
        end else begin
            case (state)
                DS_IDLE, DS_ERR2: begin
                    if (err_start) begin
                        state          <= DS_ERR1;
                        hreadyout_dflt <= 1'b0;
                        hresp_dflt     <= HRESP_ERROR;
                        last_err_addr  <= haddr;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        state          <= DS_IDLE;
                        hreadyout_dflt <= 1'b1;
                        hresp_dflt     <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state          <= DS_ERR2;
                    hreadyout_dflt <= 1'b1;
                    hresp_dflt     <= HRESP_ERROR;
                end
                default: begin
                    state          <= DS_IDLE;
                    hreadyout_dflt <= 1'b1;
                    hresp_dflt     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder_ctrl.sv
// ahb_decoder_ctrl
// Address decoder and data-phase select controller for the AHB slave-response
// multiplexor. Decodes haddr into one-hot selects (slave1 highest priority),
// registers the slave index for the data phase and holds it across wait states.
// Ports:
//   hclk, hresetn   : clock, async active-low reset
//   bus (slave)     : haddr/htrans/hready in; hsel_1..4, sel, dflt_active,
//                     hreadyout_dflt, hresp_dflt out
//   err_cnt         : saturating ERROR transfer count
//   last_err_addr   : haddr of the most recent ERROR transfer
// Build option: AHB_DEFAULT_SLAVE_EN adds the built-in default slave. Without
// it, unmapped addresses alias to slave 4 and the default-slave outputs are
// tied to their idle values.
module ahb_decoder_ctrl
    import ahb_pkg::*;
#(
    parameter logic [31:0] S1_BASE     = 32'h0000_0000,
    parameter logic [31:0] S2_BASE     = 32'h1000_0000,
    parameter logic [31:0] S3_BASE     = 32'h2000_0000,
    parameter logic [31:0] S4_BASE     = 32'h3000_0000,
    parameter int          REGION_BITS = 28
)
(
    input  logic              hclk,
    input  logic              hresetn,
    ahb_decoder_ctrl_if.slave bus,
    output logic [7:0]        err_cnt,
    output logic [31:0]       last_err_addr
);

    logic [31-REGION_BITS:0] tag;
    logic [3:0]              hit;
    logic [1:0]              idx;
    logic                    unmapped;
    logic [1:0]              sel_q;

    assign tag = bus.haddr[31:REGION_BITS];

    always_comb begin
        hit      = 4'b0000;
        idx      = 2'd0;
        unmapped = 1'b0;
        if (tag == S1_BASE[31:REGION_BITS]) begin
            hit[0] = 1'b1;
            idx    = 2'd0;
        end else if (tag == S2_BASE[31:REGION_BITS]) begin
            hit[1] = 1'b1;
            idx    = 2'd1;
        end else if (tag == S3_BASE[31:REGION_BITS]) begin
            hit[2] = 1'b1;
            idx    = 2'd2;
        end else if (tag == S4_BASE[31:REGION_BITS]) begin
            hit[3] = 1'b1;
            idx    = 2'd3;
        end else begin
`ifdef AHB_DEFAULT_SLAVE_EN
            unmapped = 1'b1;
`else
            hit[3] = 1'b1;
            idx    = 2'd3;
`endif
        end
    end

    assign bus.hsel_1 = hit[0];
    assign bus.hsel_2 = hit[1];
    assign bus.hsel_3 = hit[2];
    assign bus.hsel_4 = hit[3];

    // An unmapped transfer keeps the previous index; dflt_active steers the mux instead
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sel_q <= 2'd0;
        end else if (bus.hready && !unmapped) begin
            sel_q <= idx;
        end
    end

    assign bus.sel = sel_q;

`ifdef AHB_DEFAULT_SLAVE_EN
    logic dflt_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dflt_q <= 1'b0;
        end else if (bus.hready) begin
            dflt_q <= unmapped;
        end
    end

    assign bus.dflt_active = dflt_q;

    ahb_default_slave u_default_slave (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .haddr          (bus.haddr),
        .htrans         (bus.htrans),
        .hready         (bus.hready),
        .unmapped       (unmapped),
        .hreadyout_dflt (bus.hreadyout_dflt),
        .hresp_dflt     (bus.hresp_dflt),
        .err_cnt        (err_cnt),
        .last_err_addr  (last_err_addr)
    );
`else
    logic unused_bus;

    assign unused_bus         = ^{bus.htrans, bus.haddr[REGION_BITS-1:0]};
    assign bus.dflt_active    = 1'b0;
    assign bus.hreadyout_dflt = 1'b1;
    assign bus.hresp_dflt     = HRESP_OKAY;
    assign err_cnt            = 8'd0;
    assign last_err_addr      = 32'd0;
`endif

endmodule
